// File: rtl/pid_gain_tuner_if.sv
// pid_gain_tuner_if: bundles the button/lock inputs and the gain-bank outputs
// of pid_gain_tuner.
//   master : drives btn_inc, btn_dec, btn_sel, lock, load_defaults;
//            observes gains, sel_idx, at_limit, update
//   slave  : the tuner side of the same signals
interface pid_gain_tuner_if #(
  parameter int NUM_GAINS  = 3,
  parameter int GAIN_WIDTH = 16
);
  localparam int SEL_W = (NUM_GAINS > 1) ? $clog2(NUM_GAINS) : 1;

  logic                            btn_inc;
  logic                            btn_dec;
  logic                            btn_sel;
  logic                            lock;
  logic                            load_defaults;
  logic [NUM_GAINS*GAIN_WIDTH-1:0] gains;
  logic [SEL_W-1:0]                sel_idx;
  logic                            at_limit;
  logic                            update;

  modport master (
    output btn_inc, btn_dec, btn_sel, lock, load_defaults,
    input  gains, sel_idx, at_limit, update
  );

  modport slave (
    input  btn_inc, btn_dec, btn_sel, lock, load_defaults,
    output gains, sel_idx, at_limit, update
  );
endinterface

// File: rtl/pid_gain_tuner.sv
// pid_gain_tuner: push-button tuning engine for a bank of unsigned gains.
// btn_sel cycles the active gain; btn_inc/btn_dec step it with saturation,
// auto-repeat while held and coarse steps after a number of repeats.
// Ports:
//   clk    : system clock
//   reset  : asynchronous, active-high reset
//   bus    : pid_gain_tuner_if.slave (buttons, lock, load_defaults in;
//            gains, sel_idx, at_limit, update out)
module pid_gain_tuner #(
  parameter int NUM_GAINS     = 3,
  parameter int GAIN_WIDTH    = 16,
  parameter int STEP_FINE     = 10,
  parameter int STEP_COARSE   = 100,
  parameter int HOLD_CYCLES   = 50000000,
  parameter int REPEAT_CYCLES = 10000000,
  parameter int COARSE_AFTER  = 8,
  parameter logic [NUM_GAINS*GAIN_WIDTH-1:0] INIT_VALUES = {16'd107, 16'd0, 16'd960}
) (
  input logic             clk,
  input logic             reset,
  pid_gain_tuner_if.slave bus
);
  localparam int SEL_W   = (NUM_GAINS > 1) ? $clog2(NUM_GAINS) : 1;
  localparam int SW      = GAIN_WIDTH + 2;
  localparam int CNT_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int REP_W   = (COARSE_AFTER > 0) ? $clog2(COARSE_AFTER + 1) : 1;

  localparam logic [SW-1:0]    FINE_S     = SW'(STEP_FINE);
  localparam logic [SW-1:0]    COARSE_S   = SW'(STEP_COARSE);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_LAST   = CNT_W'(REPEAT_CYCLES - 1);
  localparam logic [REP_W-1:0] REP_COARSE = REP_W'(COARSE_AFTER);
  localparam logic [SEL_W-1:0] SEL_LAST   = SEL_W'(NUM_GAINS - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_HOLD, ST_REPEAT} state_t;
  typedef enum logic [1:0] {DIR_NONE, DIR_INC, DIR_DEC} dir_t;

  state_t                          state_r, state_n;
  dir_t                            dir_r, dir_n, dir_s;
  logic [CNT_W-1:0]                cnt_r, cnt_n;
  logic [REP_W-1:0]                rep_r, rep_n;
  logic [NUM_GAINS*GAIN_WIDTH-1:0] gains_r, gains_n;
  logic [SEL_W-1:0]                sel_r, sel_n;
  logic                            update_r, update_n;
  logic                            prev_inc_r, prev_dec_r, prev_sel_r;

  logic [GAIN_WIDTH-1:0] active_s, clamp_s;
  logic [SW-1:0]         ext_s, mag_s, sum_s;
  logic                  rise_s, sel_rise_s, coarse_s, do_step_s;

  assign active_s   = gains_r[sel_r*GAIN_WIDTH +: GAIN_WIDTH];
  assign sel_rise_s = bus.btn_sel & ~prev_sel_r;
  // A step only starts on a fresh press of the button that alone defines dir;
  // releasing one of two held buttons leaves the other high, not rising.
  assign rise_s     = ((dir_s == DIR_INC) & ~prev_inc_r) | ((dir_s == DIR_DEC) & ~prev_dec_r);
  assign coarse_s   = (state_r == ST_REPEAT) && (rep_r >= REP_COARSE);

  // Two extra bits: the MSB flags an underflow below zero, the next one an
  // overflow past the all-ones gain.
  assign ext_s = {2'b00, active_s};
  assign mag_s = coarse_s ? COARSE_S : FINE_S;
  assign sum_s = (dir_s == DIR_DEC) ? (ext_s - mag_s) : (ext_s + mag_s);

  // Decode the requested direction from the two button levels.
  always_comb begin
    dir_s = DIR_NONE;
    if (bus.btn_inc && !bus.btn_dec) begin
      dir_s = DIR_INC;
    end else if (bus.btn_dec && !bus.btn_inc) begin
      dir_s = DIR_DEC;
    end else begin
      dir_s = DIR_NONE;
    end
  end

  // Saturate the stepped value into the unsigned gain range.
  always_comb begin
    clamp_s = sum_s[GAIN_WIDTH-1:0];
    if (sum_s[SW-1]) begin
      clamp_s = {GAIN_WIDTH{1'b0}};
    end else if (sum_s[SW-2]) begin
      clamp_s = {GAIN_WIDTH{1'b1}};
    end else begin
      clamp_s = sum_s[GAIN_WIDTH-1:0];
    end
  end

  // Next-state, counter, select and gain-bank logic.
  always_comb begin
    state_n   = state_r;
    dir_n     = dir_r;
    cnt_n     = cnt_r;
    rep_n     = rep_r;
    gains_n   = gains_r;
    sel_n     = sel_r;
    update_n  = 1'b0;
    do_step_s = 1'b0;
    if (bus.load_defaults) begin
      gains_n  = INIT_VALUES;
      sel_n    = {SEL_W{1'b0}};
      state_n  = ST_IDLE;
      dir_n    = DIR_NONE;
      cnt_n    = {CNT_W{1'b0}};
      rep_n    = {REP_W{1'b0}};
      update_n = (gains_r != INIT_VALUES);
    end else if (bus.lock) begin
      state_n = ST_IDLE;
      dir_n   = DIR_NONE;
      cnt_n   = {CNT_W{1'b0}};
      rep_n   = {REP_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (dir_s != DIR_NONE && rise_s) begin
            do_step_s = 1'b1;
            state_n   = ST_HOLD;
            dir_n     = dir_s;
            cnt_n     = {CNT_W{1'b0}};
            rep_n     = {REP_W{1'b0}};
          end else begin
            state_n = ST_IDLE;
          end
          if (sel_rise_s) begin
            sel_n = (sel_r == SEL_LAST) ? {SEL_W{1'b0}} : sel_r + SEL_W'(1);
          end else begin
            sel_n = sel_r;
          end
        end
        ST_HOLD: begin
          if (dir_s != dir_r) begin
            state_n = ST_IDLE;
            dir_n   = DIR_NONE;
            cnt_n   = {CNT_W{1'b0}};
          end else if (cnt_r == HOLD_LAST) begin
            do_step_s = 1'b1;
            state_n   = ST_REPEAT;
            cnt_n     = {CNT_W{1'b0}};
            rep_n     = REP_W'(1);
          end else begin
            cnt_n = cnt_r + CNT_W'(1);
          end
        end
        ST_REPEAT: begin
          if (dir_s != dir_r) begin
            state_n = ST_IDLE;
            dir_n   = DIR_NONE;
            cnt_n   = {CNT_W{1'b0}};
            rep_n   = {REP_W{1'b0}};
          end else if (cnt_r == REP_LAST) begin
            do_step_s = 1'b1;
            cnt_n     = {CNT_W{1'b0}};
            rep_n     = (rep_r < REP_COARSE) ? rep_r + REP_W'(1) : rep_r;
          end else begin
            cnt_n = cnt_r + CNT_W'(1);
          end
        end
        default: begin
          state_n = ST_IDLE;
          dir_n   = DIR_NONE;
          cnt_n   = {CNT_W{1'b0}};
          rep_n   = {REP_W{1'b0}};
        end
      endcase
      if (do_step_s) begin
        gains_n[sel_r*GAIN_WIDTH +: GAIN_WIDTH] = clamp_s;
        update_n = (clamp_s != active_s);
      end else begin
        update_n = 1'b0;
      end
    end
  end

  // State and datapath registers; button history tracks even under lock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      dir_r      <= DIR_NONE;
      cnt_r      <= {CNT_W{1'b0}};
      rep_r      <= {REP_W{1'b0}};
      gains_r    <= INIT_VALUES;
      sel_r      <= {SEL_W{1'b0}};
      update_r   <= 1'b0;
      prev_inc_r <= 1'b0;
      prev_dec_r <= 1'b0;
      prev_sel_r <= 1'b0;
    end else begin
      state_r    <= state_n;
      dir_r      <= dir_n;
      cnt_r      <= cnt_n;
      rep_r      <= rep_n;
      gains_r    <= gains_n;
      sel_r      <= sel_n;
      update_r   <= update_n;
      prev_inc_r <= bus.btn_inc;
      prev_dec_r <= bus.btn_dec;
      prev_sel_r <= bus.btn_sel;
    end
  end

  assign bus.gains    = gains_r;
  assign bus.sel_idx  = sel_r;
  assign bus.update   = update_r;
  assign bus.at_limit = (active_s == {GAIN_WIDTH{1'b0}}) || (active_s == {GAIN_WIDTH{1'b1}});
endmodule

// File: tb/tb_pid_gain_tuner.sv
// tb_pid_gain_tuner: directed self-checking bench for pid_gain_tuner with
// short hold/repeat timing (HOLD 4, REPEAT 2, COARSE_AFTER 3).
module tb_pid_gain_tuner;
  localparam int NG = 3;
  localparam int GW = 16;

  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   upd_cnt = 0;
  int   exp_hold[20] = '{970, 970, 970, 970, 980, 980, 990, 990, 1000, 1000,
                         1100, 1100, 1200, 1200, 1300, 1300, 1400, 1400, 1500, 1500};
  int   exp_sel[3]   = '{2, 0, 1};
  logic found;

  pid_gain_tuner_if #(.NUM_GAINS(NG), .GAIN_WIDTH(GW)) bus ();

  pid_gain_tuner #(
    .NUM_GAINS(NG), .GAIN_WIDTH(GW), .STEP_FINE(10), .STEP_COARSE(100),
    .HOLD_CYCLES(4), .REPEAT_CYCLES(2), .COARSE_AFTER(3),
    .INIT_VALUES({16'd107, 16'd0, 16'd960})
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  // Single comparison point: counts and reports mismatches.
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] gain_of(input int i);
    return {16'd0, bus.gains[i*GW +: GW]};
  endfunction

  // One clock; outputs are sampled on the falling edge, update pulses tallied.
  task automatic tick();
    @(negedge clk);
    upd_cnt += int'(bus.update);
  endtask

  task automatic tap_inc();
    bus.btn_inc = 1'b1; tick(); bus.btn_inc = 1'b0; tick();
  endtask

  task automatic tap_dec();
    bus.btn_dec = 1'b1; tick(); bus.btn_dec = 1'b0; tick();
  endtask

  task automatic tap_sel();
    bus.btn_sel = 1'b1; tick(); bus.btn_sel = 1'b0; tick();
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    bus.btn_inc = 1'b0; bus.btn_dec = 1'b0; bus.btn_sel = 1'b0;
    bus.lock = 1'b0; bus.load_defaults = 1'b0;
    tick(); tick();
    reset = 1'b0;
    tick();

    // Reset state
    check_eq("rst_g0", gain_of(0), 960);
    check_eq("rst_g1", gain_of(1), 0);
    check_eq("rst_g2", gain_of(2), 107);
    check_eq("rst_sel", 32'(bus.sel_idx), 0);
    check_eq("rst_upd", 32'(bus.update), 0);
    check_eq("rst_lim", 32'(bus.at_limit), 0);

    // Hold inc on gain0 for 20 edges: fine, hold, fine repeats, then coarse
    upd_cnt = 0;
    bus.btn_inc = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      check_eq($sformatf("hold_g0_%0d", k), gain_of(0), 32'(exp_hold[k]));
      if (k == 4) check_eq("hold_upd_e4", 32'(bus.update), 1);
      if (k == 5) check_eq("hold_upd_e5", 32'(bus.update), 0);
    end
    bus.btn_inc = 1'b0;
    for (int k = 0; k < 6; k++) tick();
    check_eq("release_g0", gain_of(0), 1500);
    check_eq("hold_upd_cnt", 32'(upd_cnt), 9);

    // Lower clamp on gain1
    tap_sel();
    check_eq("sel_to1", 32'(bus.sel_idx), 1);
    upd_cnt = 0;
    tap_dec();
    check_eq("dec_clamp_g1", gain_of(1), 0);
    check_eq("dec_clamp_lim", 32'(bus.at_limit), 1);
    check_eq("dec_clamp_upd", 32'(upd_cnt), 0);

    // Drive gain1 to 65440 (10,20,30,40 then +100 steps), then 9 fine taps
    bus.btn_inc = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 3000 && !found; i++) begin
      tick();
      if (gain_of(1) == 32'd65440) found = 1'b1;
    end
    bus.btn_inc = 1'b0;
    tick();
    check_eq("reach_65440", 32'(found), 1);
    for (int i = 0; i < 9; i++) tap_inc();
    check_eq("g1_65530", gain_of(1), 65530);
    check_eq("g1_65530_lim", 32'(bus.at_limit), 0);
    bus.btn_inc = 1'b1; tick();
    check_eq("upper_clamp_g1", gain_of(1), 65535);
    check_eq("upper_clamp_upd", 32'(bus.update), 1);
    check_eq("upper_clamp_lim", 32'(bus.at_limit), 1);
    bus.btn_inc = 1'b0; tick();
    upd_cnt = 0;
    bus.btn_inc = 1'b1; tick();
    check_eq("sat_g1", gain_of(1), 65535);
    check_eq("sat_upd", 32'(bus.update), 0);
    bus.btn_inc = 1'b0; tick();
    check_eq("sat_upd_cnt", 32'(upd_cnt), 0);

    // Select wraps 1 -> 2 -> 0 -> 1
    for (int i = 0; i < 3; i++) begin
      tap_sel();
      check_eq($sformatf("sel_tap_%0d", i), 32'(bus.sel_idx), 32'(exp_sel[i]));
    end
    check_eq("sel_keeps_g0", gain_of(0), 1500);

    // Select edge while inc is held is dropped
    bus.btn_inc = 1'b1; tick();
    tap_sel();
    check_eq("sel_in_hold", 32'(bus.sel_idx), 1);
    bus.btn_inc = 1'b0; tick();

    // Back to gain0, then inc+dec together
    tap_sel(); tap_sel();
    check_eq("sel_to0", 32'(bus.sel_idx), 0);
    bus.btn_inc = 1'b1; bus.btn_dec = 1'b1; tick(); tick();
    check_eq("both_g0", gain_of(0), 1500);
    bus.btn_inc = 1'b0; bus.btn_dec = 1'b0; tick();

    // Hold inc, raise dec before the hold step, drop dec with inc held
    bus.btn_inc = 1'b1; tick();
    check_eq("press_g0", gain_of(0), 1510);
    tick(); tick();
    bus.btn_dec = 1'b1;
    for (int k = 0; k < 6; k++) tick();
    check_eq("inc_then_dec_g0", gain_of(0), 1510);
    bus.btn_dec = 1'b0;
    for (int k = 0; k < 6; k++) tick();
    check_eq("drop_dec_g0", gain_of(0), 1510);
    bus.btn_inc = 1'b0; tick();

    // Lock freezes; button held across unlock does not step
    bus.lock = 1'b1; bus.btn_inc = 1'b1;
    for (int k = 0; k < 3; k++) tick();
    check_eq("lock_g0", gain_of(0), 1510);
    bus.lock = 1'b0;
    for (int k = 0; k < 6; k++) tick();
    check_eq("unlock_g0", gain_of(0), 1510);
    bus.btn_inc = 1'b0; tick();

    // load_defaults restores everything with a single update pulse
    tap_sel();
    upd_cnt = 0;
    bus.load_defaults = 1'b1; tick();
    check_eq("ld_upd", 32'(bus.update), 1);
    check_eq("ld_g0", gain_of(0), 960);
    check_eq("ld_g1", gain_of(1), 0);
    check_eq("ld_g2", gain_of(2), 107);
    check_eq("ld_sel", 32'(bus.sel_idx), 0);
    bus.load_defaults = 1'b0; tick();
    check_eq("ld_upd_cnt", 32'(upd_cnt), 1);
    bus.load_defaults = 1'b1; tick();
    check_eq("ld_again_upd", 32'(bus.update), 0);
    bus.load_defaults = 1'b0; tick();

    // Reset while repeating on gain2
    tap_sel(); tap_sel();
    bus.btn_inc = 1'b1;
    for (int k = 0; k < 8; k++) tick();
    check_eq("pre_rst_g2", gain_of(2), 137);
    reset = 1'b1; #1;
    check_eq("mid_rst_g2", gain_of(2), 107);
    check_eq("mid_rst_sel", 32'(bus.sel_idx), 0);
    bus.btn_inc = 1'b0;
    tick();
    reset = 1'b0;
    for (int k = 0; k < 6; k++) tick();
    check_eq("post_rst_g0", gain_of(0), 960);
    bus.btn_inc = 1'b1; tick();
    check_eq("post_rst_step", gain_of(0), 970);
    bus.btn_inc = 1'b0; tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
